// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: credit-limited imem requests feeding a 2-entry {pc, instruction} buffer to decode.
// Define FETCH_ALIGN_CHECK_EN to fault on misaligned redirect targets instead of silently aligning them.
module cpu_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  output logic        o_fault
);

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_DRAIN} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;
  logic [1:0]  outstanding_next;
  logic [2:0]  credits_used;

  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] pc_mem [2];
  logic [31:0] instr_mem [2];

  logic        addr_rd;
  logic        addr_wr;
  logic [31:0] addr_mem [2];

  logic        grant;
  logic        resp;
  logic        push;
  logic        pop;
  logic        blocked;
  logic [31:0] target_pc;

  // A pop in the same cycle frees its slot, which is what lets zero-wait memory sustain one word per cycle
  assign o_valid      = (count != 2'd0);
  assign pop          = o_valid && i_ready;
  assign credits_used = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};
  assign o_imem_req   = (state == S_FETCH) && !blocked && (credits_used < 3'd2);
  assign o_imem_addr  = (state == S_RESET) ? 32'h0 : (fetch_pc & ~32'h3);
  assign grant        = o_imem_req && i_imem_gnt;
  assign resp         = i_imem_rvalid && (outstanding != 2'd0);
  assign push         = resp && (state == S_FETCH) && !i_redirect;

  assign outstanding_next = outstanding + {1'b0, grant} - {1'b0, resp};

  assign o_pc          = pc_mem[rd_ptr];
  assign o_instruction = instr_mem[rd_ptr];

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault;

  assign target_pc = i_redirect_pc;
  assign blocked   = fault;
  assign o_fault   = fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (i_redirect) begin
      fault <= (i_redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign target_pc = i_redirect_pc & ~32'h3;
  assign blocked   = 1'b0;
  assign o_fault   = 1'b0;
`endif

  // Every response still in flight at a redirect is stale; drain them before fetching again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RESET;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
    end else begin
      outstanding <= outstanding_next;
      if (i_redirect) begin
        fetch_pc <= target_pc;
        state    <= (outstanding_next != 2'd0) ? S_DRAIN : S_FETCH;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        case (state)
          S_RESET: state <= S_FETCH;
          S_FETCH: state <= S_FETCH;
          S_DRAIN: if (outstanding_next == 2'd0) state <= S_FETCH;
          default: state <= S_RESET;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_rd <= 1'b0;
      addr_wr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_mem[i] <= 32'h0;
      end
    end else begin
      if (grant) begin
        addr_mem[addr_wr] <= o_imem_addr;
        addr_wr           <= ~addr_wr;
      end
      if (resp) begin
        addr_rd <= ~addr_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]    <= 32'h0;
        instr_mem[i] <= 32'h0;
      end
    end else if (i_redirect) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= addr_mem[addr_rd];
        instr_mem[wr_ptr] <= i_imem_rdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed table-driven bench for cpu_fetch_unit with an in-order imem model of per-grant latency.
// Expectations follow the default build, or the fault behaviour when FETCH_ALIGN_CHECK_EN is defined.
module tb_cpu_fetch_unit;

  logic        clk;
  logic        rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        i_ready;
  logic        o_fault;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        spur;
    int          lat;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  vec_t  vecs[$];
  mreq_t mq[$];
  int    cyc;
  int    checks;
  int    errors;

  cpu_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .i_ready       (i_ready),
    .o_fault       (o_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic row(input logic rs, input logic rdy, input logic rd, input logic [31:0] rpc,
                     input logic sp, input int lat, input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep, input logic ef);
    vec_t v;
    v.rst = rs; v.ready = rdy; v.redir = rd; v.rpc = rpc; v.spur = sp; v.lat = lat;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_fault = ef;
    vecs.push_back(v);
  endtask

  task automatic expectEq(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, idx, got, want);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; the memory model answers the oldest due grant
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    i_ready       = v.ready;
    i_redirect    = v.redir;
    i_redirect_pc = v.rpc;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    if (v.rst) begin
      mq.delete();
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = instr_of(mq[0].addr);
      mq.delete(0);
    end else if (v.spur) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    mreq_t m;
    expectEq("imem_req", idx, {31'b0, o_imem_req}, {31'b0, v.exp_req});
    if (v.exp_req) expectEq("imem_addr", idx, o_imem_addr, v.exp_addr);
    expectEq("valid", idx, {31'b0, o_valid}, {31'b0, v.exp_valid});
    if (v.exp_valid) begin
      expectEq("pc", idx, o_pc, v.exp_pc);
      expectEq("instruction", idx, o_instruction, instr_of(v.exp_pc));
    end
    expectEq("fault", idx, {31'b0, o_fault}, {31'b0, v.exp_fault});
    if (!v.rst && o_imem_req && i_imem_gnt) begin
      m.addr = o_imem_addr;
      m.due  = cyc + v.lat;
      mq.push_back(m);
    end
    cyc++;
  endtask

  initial begin
    int waited;
    clk = 1'b0; rst = 1'b1; i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    i_redirect = 1'b0; i_redirect_pc = 32'h0; i_ready = 1'b1;
    cyc = 0; checks = 0; errors = 0;

    // Reset start-up, full-rate streaming, then reset mid-transaction
    row(1,1,0,0,0,1, 0,0,           0,0,           0);
    row(0,1,0,0,0,1, 0,0,           0,0,           0);
    row(0,1,0,0,0,1, 1,32'h100,     0,0,           0);
    row(0,1,0,0,0,1, 1,32'h104,     0,0,           0);
    row(0,1,0,0,0,1, 1,32'h108,     1,32'h100,     0);
    row(0,1,0,0,0,1, 1,32'h10C,     1,32'h104,     0);
    row(0,1,0,0,0,1, 1,32'h110,     1,32'h108,     0);
    row(1,1,0,0,0,1, 0,0,           0,0,           0);
    // Decode stalled for 10 cycles with the buffer full, then resumes
    row(0,0,0,0,0,1, 0,0,           0,0,           0);
    row(0,0,0,0,0,1, 1,32'h100,     0,0,           0);
    row(0,0,0,0,0,1, 1,32'h104,     0,0,           0);
    for (int i = 0; i < 10; i++) row(0,0,0,0,0,1, 0,0, 1,32'h100, 0);
    row(0,1,0,0,0,1, 1,32'h108,     1,32'h100,     0);
    row(0,1,0,0,0,1, 1,32'h10C,     1,32'h104,     0);
    row(0,1,0,0,0,1, 1,32'h110,     1,32'h108,     0);
    row(0,1,0,0,0,1, 1,32'h114,     1,32'h10C,     0);
    // Redirect in the same cycle as a pop and a stale grant
    row(0,1,1,32'h40,0,1, 1,32'h118, 1,32'h110,     0);
    row(0,1,0,0,0,1, 0,0,           0,0,           0);
    row(0,1,0,0,0,1, 1,32'h40,      0,0,           0);
    row(0,1,0,0,0,1, 1,32'h44,      0,0,           0);
    row(0,1,0,0,0,1, 1,32'h48,      1,32'h40,      0);
    // Redirect with nothing stale, then a spurious rvalid with zero outstanding
    row(0,0,1,32'h80,0,1, 0,0,      1,32'h44,      0);
    row(0,0,0,0,1,1, 1,32'h80,      0,0,           0);
    row(0,0,0,0,0,3, 1,32'h84,      0,0,           0);
    row(0,1,0,0,0,3, 1,32'h88,      1,32'h80,      0);
    // Three-cycle memory: redirect with two responses in flight
    row(0,1,1,32'h200,0,3, 0,0,     0,0,           0);
    row(0,1,0,0,0,3, 0,0,           0,0,           0);
    row(0,1,0,0,0,3, 0,0,           0,0,           0);
    row(0,1,0,0,0,3, 1,32'h200,     0,0,           0);
    row(0,1,0,0,0,3, 1,32'h204,     0,0,           0);
    row(0,1,0,0,0,3, 0,0,           0,0,           0);
    row(0,1,0,0,0,3, 0,0,           0,0,           0);
    row(0,1,0,0,0,3, 1,32'h208,     1,32'h200,     0);
    row(0,1,0,0,0,3, 1,32'h20C,     1,32'h204,     0);
    // Fetch PC wrap-around
    row(0,1,1,32'hFFFF_FFF8,0,1, 0,0, 0,0,         0);
    row(0,1,0,0,0,1, 0,0,           0,0,           0);
    row(0,1,0,0,0,1, 0,0,           0,0,           0);
    row(0,1,0,0,0,1, 1,32'hFFFF_FFF8, 0,0,         0);
    row(0,1,0,0,0,1, 1,32'hFFFF_FFFC, 0,0,         0);
    row(0,1,0,0,0,1, 1,32'h0,       1,32'hFFFF_FFF8, 0);
    row(0,1,0,0,0,1, 1,32'h4,       1,32'hFFFF_FFFC, 0);
    row(0,1,0,0,0,1, 1,32'h8,       1,32'h0,       0);
    // Misaligned redirect target
    row(0,1,1,32'h302,0,1, 1,32'hC, 1,32'h4,       0);
`ifdef FETCH_ALIGN_CHECK_EN
    row(0,1,0,0,0,1, 0,0,           0,0,           1);
    row(0,1,1,32'h300,0,1, 0,0,     0,0,           1);
    row(0,1,0,0,0,1, 1,32'h300,     0,0,           0);
    row(0,1,0,0,0,1, 1,32'h304,     0,0,           0);
    row(0,1,0,0,0,1, 1,32'h308,     1,32'h300,     0);
`else
    row(0,1,0,0,0,1, 0,0,           0,0,           0);
    row(0,1,0,0,0,1, 1,32'h300,     0,0,           0);
    row(0,1,0,0,0,1, 1,32'h304,     0,0,           0);
    row(0,1,0,0,0,1, 1,32'h308,     1,32'h300,     0);
`endif

    repeat (2) @(negedge clk);
    #1;
    expectEq("rst_req",   -1, {31'b0, o_imem_req}, 32'h0);
    expectEq("rst_valid", -1, {31'b0, o_valid},    32'h0);
    expectEq("rst_fault", -1, {31'b0, o_fault},    32'h0);
    expectEq("rst_addr",  -1, o_imem_addr,         32'h0);
    expectEq("rst_pc",    -1, o_pc,                32'h0);
    expectEq("rst_instr", -1, o_instruction,       32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Asynchronous reset between clock edges, then count cycles to the first request
    @(posedge clk);
    #2;
    rst = 1'b1;
    i_redirect = 1'b0;
    i_imem_rvalid = 1'b0;
    #1;
    expectEq("async_rst_req",   -2, {31'b0, o_imem_req}, 32'h0);
    expectEq("async_rst_valid", -2, {31'b0, o_valid},    32'h0);
    @(negedge clk);
    rst = 1'b0;
    i_ready = 1'b1;
    #1;
    expectEq("post_rst_idle", -2, {31'b0, o_imem_req}, 32'h0);
    waited = 0;
    while (!o_imem_req && waited < 6) begin
      @(negedge clk);
      #1;
      waited++;
    end
    expectEq("first_req_delay", -2, waited, 1);
    expectEq("first_req_addr",  -2, o_imem_addr, 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
